// File: rtl/afu_rd_reorder_pkg.sv
// afu_rd_reorder_pkg: shared types and constants for the read-response reorder buffer.
// Revision: 1.0
`default_nettype none

package afu_rd_reorder_pkg;

  localparam int ORPHAN_CNT_W = 16;

  typedef struct packed {
    logic [3:0] qos;
    logic [1:0] resp;
    logic       poison;
    logic [8:0] tag;
  } t_rd_rsp_user;

  function automatic logic [ORPHAN_CNT_W-1:0] sat_inc(input logic [ORPHAN_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/afu_oldest_match.sv
// afu_oldest_match: finds the oldest allocated, unfilled slot whose id equals mc_rid.
// Revision: 1.0
`default_nettype none

module afu_oldest_match #(
  parameter int N      = 64,
  parameter int ADDR_W = 6,
  parameter int ID_BW  = 8
) (
  input  logic [N-1:0]       alloc,
  input  logic [N-1:0]       filled,
  input  logic [N*ID_BW-1:0] ids,
  input  logic [ADDR_W-1:0]  rd_ptr,
  input  logic [ID_BW-1:0]   mc_rid,
  output logic               hit,
  output logic [ADDR_W-1:0]  idx
);

  logic [N-1:0]      cand;
  logic [N-1:0]      rot;
  logic [ADDR_W-1:0] rot_idx;

  for (genvar i = 0; i < N; i++) begin : g_cand
    assign cand[i] = alloc[i] & ~filled[i] & (ids[i*ID_BW +: ID_BW] == mc_rid);
  end

  // Rotate so that bit 0 is the head slot; the lowest set bit is then the oldest.
  for (genvar k = 0; k < N; k++) begin : g_rot
    logic [ADDR_W-1:0] src;
    assign src    = rd_ptr + ADDR_W'(k);
    assign rot[k] = cand[src];
  end

  always_comb begin
    rot_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) rot_idx = ADDR_W'(k);
    end
  end

  assign hit = |cand;
  assign idx = rot_idx + rd_ptr;

endmodule

`default_nettype wire

// File: rtl/afu_rd_reorder.sv
// afu_rd_reorder: records AR issue order and replays MC read responses in that order.
// Revision: 1.0
`default_nettype none

module afu_rd_reorder
  import afu_rd_reorder_pkg::*;
#(
  parameter int FIFO_DEPTH  = 64,
  parameter int FIFO_ADDR_W = $clog2(FIFO_DEPTH),
  parameter int DATA_BW     = 512,
  parameter int ID_BW       = 8,
  parameter int RUSER_BW    = $bits(t_rd_rsp_user)
) (
  input  logic                    afu_clk,
  input  logic                    afu_rstn,
  input  logic                    up_arvalid,
  input  logic [ID_BW-1:0]        up_arid,
  output logic                    up_arready,
  output logic                    dn_arvalid,
  input  logic                    dn_arready,
  input  logic                    mc_rvalid,
  input  logic [ID_BW-1:0]        mc_rid,
  input  logic [DATA_BW-1:0]      mc_rdata,
  input  logic [RUSER_BW-1:0]     mc_ruser,
  output logic                    mc_rready,
  output logic                    out_rvalid,
  input  logic                    out_rready,
  output logic [ID_BW-1:0]        out_rid,
  output logic [DATA_BW-1:0]      out_rdata,
  output logic [RUSER_BW-1:0]     out_ruser,
  output logic                    out_rlast,
  output logic [FIFO_ADDR_W:0]    occupancy,
  output logic [ORPHAN_CNT_W-1:0] orphan_cnt,
  output logic                    orphan_err
);

  localparam int N = FIFO_DEPTH;

  typedef struct packed {
    logic [ID_BW-1:0]    id;
    logic [RUSER_BW-1:0] user;
    logic [DATA_BW-1:0]  data;
  } t_slot;

  t_slot                  slots [N];
  logic [N-1:0]           alloc;
  logic [N-1:0]           filled;
  logic [N*ID_BW-1:0]     id_flat;
  logic [FIFO_ADDR_W:0]   wr_ptr;
  logic [FIFO_ADDR_W:0]   rd_ptr;
  logic [FIFO_ADDR_W-1:0] wr_idx;
  logic [FIFO_ADDR_W-1:0] head;
  logic [FIFO_ADDR_W-1:0] match_idx;
  logic                   full;
  logic                   empty;
  logic                   ar_fire;
  logic                   pop;
  logic                   hit;
  logic                   match_fire;
  logic                   orphan;

  assign wr_idx = wr_ptr[FIFO_ADDR_W-1:0];
  assign head   = rd_ptr[FIFO_ADDR_W-1:0];
  assign full   = (wr_ptr[FIFO_ADDR_W] != rd_ptr[FIFO_ADDR_W]) && (wr_idx == head);
  assign empty  = (wr_ptr == rd_ptr);

  assign up_arready = dn_arready & ~full;
  assign dn_arvalid = up_arvalid & ~full;
  assign ar_fire    = up_arvalid & dn_arready & ~full;

  assign out_rvalid = ~empty & filled[head];
  assign out_rlast  = out_rvalid;
  assign pop        = out_rvalid & out_rready;
  assign out_rid    = out_rvalid ? slots[head].id   : '0;
  assign out_rdata  = out_rvalid ? slots[head].data : '0;
  assign out_ruser  = out_rvalid ? slots[head].user : '0;
  assign occupancy  = wr_ptr - rd_ptr;

  for (genvar i = 0; i < N; i++) begin : g_id_flat
    assign id_flat[i*ID_BW +: ID_BW] = slots[i].id;
  end

  afu_oldest_match #(
    .N      (N),
    .ADDR_W (FIFO_ADDR_W),
    .ID_BW  (ID_BW)
  ) u_match (
    .alloc  (alloc),
    .filled (filled),
    .ids    (id_flat),
    .rd_ptr (head),
    .mc_rid (mc_rid),
    .hit    (hit),
    .idx    (match_idx)
  );

  assign match_fire = mc_rvalid & mc_rready & hit;
  assign orphan     = mc_rvalid & mc_rready & ~hit;

  // Allocate, match and pop always target distinct slots, so their writes never collide.
  always_ff @(posedge afu_clk or negedge afu_rstn) begin
    if (!afu_rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      alloc      <= '0;
      filled     <= '0;
      mc_rready  <= 1'b0;
      orphan_cnt <= '0;
      orphan_err <= 1'b0;
    end else begin
      mc_rready <= 1'b1;
      if (pop) begin
        alloc[head]  <= 1'b0;
        filled[head] <= 1'b0;
        rd_ptr       <= rd_ptr + 1'b1;
      end
      if (ar_fire) begin
        alloc[wr_idx]  <= 1'b1;
        filled[wr_idx] <= 1'b0;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (match_fire) begin
        filled[match_idx] <= 1'b1;
      end
      if (orphan) begin
        orphan_err <= 1'b1;
        orphan_cnt <= sat_inc(orphan_cnt);
      end
    end
  end

  always_ff @(posedge afu_clk) begin
    if (ar_fire) begin
      slots[wr_idx].id <= up_arid;
    end
    if (match_fire) begin
      slots[match_idx].data <= mc_rdata;
      slots[match_idx].user <= mc_ruser;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_afu_rd_reorder.sv
// tb_afu_rd_reorder: randomized and directed checks against a queue-based reorder model.
// Revision: 1.0
`default_nettype none

module tb_afu_rd_reorder;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int DW    = 512;
  localparam int IW    = 8;
  localparam int UW    = 16;

  logic          afu_clk = 1'b0;
  logic          afu_rstn;
  logic          up_arvalid;
  logic [IW-1:0] up_arid;
  logic          up_arready;
  logic          dn_arvalid;
  logic          dn_arready;
  logic          mc_rvalid;
  logic [IW-1:0] mc_rid;
  logic [DW-1:0] mc_rdata;
  logic [UW-1:0] mc_ruser;
  logic          mc_rready;
  logic          out_rvalid;
  logic          out_rready;
  logic [IW-1:0] out_rid;
  logic [DW-1:0] out_rdata;
  logic [UW-1:0] out_ruser;
  logic          out_rlast;
  logic [AW:0]   occupancy;
  logic [15:0]   orphan_cnt;
  logic          orphan_err;

  always #5 afu_clk = ~afu_clk;

  afu_rd_reorder dut (
    .afu_clk    (afu_clk),
    .afu_rstn   (afu_rstn),
    .up_arvalid (up_arvalid),
    .up_arid    (up_arid),
    .up_arready (up_arready),
    .dn_arvalid (dn_arvalid),
    .dn_arready (dn_arready),
    .mc_rvalid  (mc_rvalid),
    .mc_rid     (mc_rid),
    .mc_rdata   (mc_rdata),
    .mc_ruser   (mc_ruser),
    .mc_rready  (mc_rready),
    .out_rvalid (out_rvalid),
    .out_rready (out_rready),
    .out_rid    (out_rid),
    .out_rdata  (out_rdata),
    .out_ruser  (out_ruser),
    .out_rlast  (out_rlast),
    .occupancy  (occupancy),
    .orphan_cnt (orphan_cnt),
    .orphan_err (orphan_err)
  );

  // Model: outstanding reads in issue order; each knows whether its response arrived.
  typedef struct {
    logic [IW-1:0] id;
    bit            filled;
    logic [DW-1:0] data;
    logic [UW-1:0] user;
  } ent_t;

  ent_t mq[$];
  int   m_ocnt;
  bit   m_oerr;
  bit   m_rready;
  int   n_pass;
  int   n_total;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic compare();
    bit ev;
    bit mfull;
    ev    = (mq.size() > 0) && mq[0].filled;
    mfull = (mq.size() == DEPTH);
    chk("out_rvalid", out_rvalid, ev);
    chk("out_rlast",  out_rlast,  ev);
    chk("out_rid",    out_rid,    ev ? mq[0].id   : '0);
    chk("out_rdata",  out_rdata,  ev ? mq[0].data : '0);
    chk("out_ruser",  out_ruser,  ev ? mq[0].user : '0);
    chk("occupancy",  occupancy,  mq.size());
    chk("up_arready", up_arready, dn_arready && !mfull);
    chk("dn_arvalid", dn_arvalid, up_arvalid && !mfull);
    chk("mc_rready",  mc_rready,  m_rready);
    chk("orphan_cnt", orphan_cnt, m_ocnt);
    chk("orphan_err", orphan_err, m_oerr);
  endtask

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    bit            do_pop;
    bit            do_ar;
    bit            do_r;
    int            mi;
    logic [IW-1:0] aid;
    ent_t          e;
    if (!afu_rstn) begin
      mq.delete();
      m_ocnt   = 0;
      m_oerr   = 0;
      m_rready = 0;
    end
    #1;
    compare();
    do_pop = (mq.size() > 0) && mq[0].filled && out_rready;
    do_ar  = up_arvalid && dn_arready && (mq.size() < DEPTH);
    do_r   = mc_rvalid && m_rready;
    aid    = up_arid;
    mi     = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (mi < 0 && !mq[i].filled && mq[i].id == mc_rid) mi = i;
    end
    e.id = aid; e.filled = 0; e.data = '0; e.user = '0;
    if (do_r && mi >= 0) begin
      mq[mi].filled = 1;
      mq[mi].data   = mc_rdata;
      mq[mi].user   = mc_ruser;
    end
    @(posedge afu_clk);
    if (afu_rstn) begin
      if (do_r && mi < 0) begin
        m_oerr = 1;
        if (m_ocnt < 65535) m_ocnt++;
      end
      if (do_pop) void'(mq.pop_front());
      if (do_ar) mq.push_back(e);
      m_rready = 1;
    end else begin
      mq.delete();
    end
    @(negedge afu_clk);
  endtask

  task automatic idle_inputs();
    up_arvalid = 0; up_arid = '0; dn_arready = 1;
    mc_rvalid = 0; mc_rid = '0; mc_rdata = '0; mc_ruser = '0;
    out_rready = 1;
  endtask

  task automatic ar(input logic [IW-1:0] id);
    idle_inputs();
    up_arvalid = 1; up_arid = id;
    tick();
  endtask

  task automatic rsp(input logic [IW-1:0] id, input logic [DW-1:0] d, input logic [UW-1:0] u);
    idle_inputs();
    mc_rvalid = 1; mc_rid = id; mc_rdata = d; mc_ruser = u;
    tick();
  endtask

  task automatic do_reset();
    idle_inputs();
    afu_rstn = 0;
    tick();
    chk("lit_rst_mc_rready", mc_rready, 0);
    tick();
    afu_rstn = 1;
    tick();
    chk("lit_rst_occ", occupancy, 0);
    chk("lit_rst_rvalid", out_rvalid, 0);
    chk("lit_rst_ocnt", orphan_cnt, 0);
    chk("lit_rst_up_arready", up_arready, 1);
  endtask

  initial begin
    int c[$];
    n_pass = 0; n_total = 0;
    m_ocnt = 0; m_oerr = 0; m_rready = 0;
    idle_inputs();
    afu_rstn = 0;
    @(negedge afu_clk);
    do_reset();

    // In order
    for (int i = 1; i <= 4; i++) ar(IW'(i));
    for (int i = 1; i <= 4; i++) begin
      rsp(IW'(i), DW'(32'hA0 + i), UW'(i));
      chk("lit_inord_valid", out_rvalid, 1);
      chk("lit_inord_id", out_rid, i);
      chk("lit_inord_data", out_rdata, 32'hA0 + i);
    end
    idle_inputs(); tick();
    chk("lit_inord_empty", occupancy, 0);

    // Reorder
    ar(5); ar(6); ar(7);
    rsp(7, 'h77, 7);
    chk("lit_reord_hold", out_rvalid, 0);
    rsp(5, 'h55, 5);
    chk("lit_reord_5", out_rid, 5);
    rsp(6, 'h66, 6);
    chk("lit_reord_6", out_rid, 6);
    idle_inputs(); tick();
    chk("lit_reord_7", out_rid, 7);
    idle_inputs(); tick();

    // Same ID
    ar(3); ar(3); ar(4);
    rsp(4, 'h44, 0); rsp(3, 'hAA, 0);
    chk("lit_same_x", out_rdata, 'hAA);
    rsp(3, 'hBB, 0);
    chk("lit_same_y", out_rdata, 'hBB);
    idle_inputs(); tick();
    chk("lit_same_4", out_rid, 4);
    idle_inputs(); tick();

    // Orphan
    rsp(9, 'h99, 0);
    chk("lit_orph_err", orphan_err, 1);
    chk("lit_orph_cnt", orphan_cnt, 1);
    chk("lit_orph_occ", occupancy, 0);
    chk("lit_orph_valid", out_rvalid, 0);

    // Full, then one pop admits exactly one more AR
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs(); out_rready = 0; up_arvalid = 1; up_arid = IW'(i % 8);
      tick();
    end
    chk("lit_full_arready", up_arready, 0);
    chk("lit_full_occ", occupancy, 64);
    idle_inputs(); out_rready = 0; up_arvalid = 1; up_arid = 8'hE0;
    mc_rvalid = 1; mc_rid = 0; mc_rdata = 'h1234;
    tick();
    chk("lit_full_noalloc", occupancy, 64);
    idle_inputs(); up_arvalid = 1; up_arid = 8'hE1;
    tick();
    chk("lit_full_pop", occupancy, 63);
    idle_inputs(); out_rready = 0; up_arvalid = 1; up_arid = 8'hE2;
    tick();
    tick();
    chk("lit_full_one_more", occupancy, 64);

    // Randomized traffic: drains the full buffer and wraps the pointers many times
    for (int cyc = 0; cyc < 4000; cyc++) begin
      idle_inputs();
      up_arvalid = ($urandom_range(0, 9) < 7);
      up_arid    = IW'($urandom_range(0, 7));
      dn_arready = ($urandom_range(0, 9) < 8);
      out_rready = ($urandom_range(0, 9) < 7);
      mc_rvalid  = ($urandom_range(0, 9) < 7);
      c.delete();
      foreach (mq[i]) if (!mq[i].filled) c.push_back(i);
      if (c.size() > 0 && $urandom_range(0, 19) != 0) mc_rid = mq[c[$urandom_range(0, c.size() - 1)]].id;
      else mc_rid = IW'($urandom_range(8, 15));
      for (int w = 0; w < DW / 32; w++) mc_rdata[w*32 +: 32] = $urandom;
      mc_ruser = UW'($urandom);
      tick();
    end

    // Reset mid-flight
    idle_inputs(); out_rready = 0; tick();
    for (int i = 0; i < 200 && occupancy != 0; i++) begin
      idle_inputs(); mc_rvalid = 0;
      c.delete();
      foreach (mq[k]) if (!mq[k].filled) c.push_back(k);
      if (c.size() > 0) begin mc_rvalid = 1; mc_rid = mq[c[0]].id; end
      tick();
    end
    chk("lit_mid_drained", occupancy, 0);
    for (int i = 0; i < 10; i++) begin
      idle_inputs(); out_rready = 0; up_arvalid = 1; up_arid = IW'(i);
      tick();
    end
    for (int i = 1; i <= 3; i++) begin
      idle_inputs(); out_rready = 0; mc_rvalid = 1; mc_rid = IW'(i); mc_rdata = DW'(i);
      tick();
    end
    chk("lit_mid_occ10", occupancy, 10);
    do_reset();
    ar(2);
    rsp(2, 'hC2, 2);
    chk("lit_mid_after_id", out_rid, 2);
    chk("lit_mid_after_data", out_rdata, 'hC2);
    idle_inputs(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
